// File: rtl/deskew_sequencer.sv
// deskew_sequencer: loads one image into BRAM port A, runs Deskew, then streams the result back out
module deskew_sequencer #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int IMG_SIZE   = 784,
    parameter int OUT_BASE   = 784
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  dskw_start,
    input  logic                  dskw_ready,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_address,
    output logic [WIDTH-1:0]      bram_in_data,
    input  logic [WIDTH-1:0]      bram_out_data,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = $clog2(IMG_SIZE);
    localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ARM, KICK, RUN, RD_ISSUE, RD_CAPT, RD_HOLD} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          xfer, at_last;

    // state register, word index and the registered result word
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == RD_CAPT) out_data <= bram_out_data;
        end
    end

    // next state, index update and port A / stream outputs
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        xfer         = state == LOAD && in_valid;
        at_last      = cnt == LAST;
        in_ready     = state == LOAD;
        out_valid    = state == RD_HOLD;
        out_last     = out_valid && at_last;
        done         = out_valid && out_ready && at_last;
        dskw_start   = state == KICK;
        busy         = state != IDLE;
        bram_en      = xfer || state == RD_ISSUE;
        bram_we      = xfer;
        bram_address = xfer ? ADDR_WIDTH'(cnt)
                     : state == RD_ISSUE ? ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(cnt) : '0;
        bram_in_data = xfer ? in_data : '0;
        case (state)
            IDLE: if (in_valid) begin
                state_nx = LOAD;
                cnt_nx   = '0;
            end
            LOAD: if (xfer) begin
                cnt_nx   = at_last ? '0 : cnt + 1'b1;
                state_nx = at_last ? ARM : LOAD;
            end
            ARM:      if (dskw_ready) state_nx = KICK;
            KICK:     if (!dskw_ready) state_nx = RUN;
            RUN:      if (dskw_ready) state_nx = RD_ISSUE;
            RD_ISSUE: state_nx = RD_CAPT;
            RD_CAPT:  state_nx = RD_HOLD;
            RD_HOLD: if (out_ready) begin
                cnt_nx   = at_last ? '0 : cnt + 1'b1;
                state_nx = at_last ? IDLE : RD_ISSUE;
            end
            default:  state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_deskew_sequencer.sv
// tb_deskew_sequencer: random image jobs through the sequencer with a BRAM and Deskew model alongside
module tb_deskew_sequencer;
    localparam int W   = 16;
    localparam int AW  = 11;
    localparam int IMG = 784;
    localparam int OB  = 784;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, out_valid, out_last, dskw_start, dskw_ready;
    logic          bram_en, bram_we, busy, done;
    logic [W-1:0]  out_data, bram_in_data, bram_out_data;
    logic [AW-1:0] bram_address;

    logic [W-1:0]  mem [0:2**AW-1];
    logic [W-1:0]  pix [0:IMG-1];
    logic [W-1:0]  key = '0;
    logic          hold_low = 1'b0;
    logic          dsk_rdy = 1'b1;
    logic          dsk_busy = 1'b0;
    int            dsk_t = 0;
    int            n_fin = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    assign dskw_ready = dsk_rdy && !hold_low;

    deskew_sequencer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .dskw_start(dskw_start), .dskw_ready(dskw_ready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_address(bram_address),
        .bram_in_data(bram_in_data), .bram_out_data(bram_out_data),
        .busy(busy), .done(done)
    );

    // BRAM port A, and a Deskew engine that drops ready after a start and writes pixel^key back
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_address] <= bram_in_data;
            bram_out_data <= mem[bram_address];
        end
        if (!dsk_busy) begin
            if (dskw_start) begin
                dsk_busy <= 1'b1;
                dsk_t    <= 1;
            end
        end else begin
            dsk_t <= dsk_t + 1;
            if (dsk_t == 1) dsk_rdy <= 1'b0;
            if (dsk_t == 21) begin
                dsk_rdy  <= 1'b1;
                dsk_busy <= 1'b0;
                n_fin    <= n_fin + 1;
                for (int i = 0; i < IMG; i++) mem[OB + i] <= mem[i] ^ key;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_in_ready"}, 32'(in_ready), 0);
        chk({t, "_out_valid"}, 32'(out_valid), 0);
        chk({t, "_out_last"}, 32'(out_last), 0);
        chk({t, "_out_data"}, 32'(out_data), 0);
        chk({t, "_dskw_start"}, 32'(dskw_start), 0);
        chk({t, "_bram_en"}, 32'(bram_en), 0);
        chk({t, "_bram_we"}, 32'(bram_we), 0);
        chk({t, "_bram_address"}, 32'(bram_address), 0);
        chk({t, "_bram_in_data"}, 32'(bram_in_data), 0);
        chk({t, "_busy"}, 32'(busy), 0);
        chk({t, "_done"}, 32'(done), 0);
    endtask

    task automatic run_job(input int gap, input int stall, input bit ramp, input bit hold, input int abort_at);
        int   hi = 0;
        int   oi = 0;
        int   dn = 0;
        int   h = 0;
        int   cyc = 0;
        int   fin0;
        logic p_start, p_rdy;
        bit   loaded, fin;
        for (int i = 0; i < IMG; i++) pix[i] = ramp ? W'(i) : W'($urandom);
        key = ramp ? 16'hA5A5 : W'($urandom);
        hold_low = hold;
        fin0 = n_fin;
        p_start = dskw_start;
        p_rdy = dskw_ready;
        while (dn == 0 && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (abort_at >= 0 && hi >= abort_at) begin
                reset = 1'b0;
                in_valid = 1'b0;
                out_ready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk_zero("abort");
                @(posedge clk);
                #1;
                reset = 1'b1;
                return;
            end
            if (hold_low && hi == IMG) begin
                h++;
                if (h > 50) hold_low = 1'b0;
            end
            in_valid = hi < IMG && int'($urandom_range(99)) >= gap;
            in_data = hi < IMG ? pix[hi] : W'($urandom);
            out_ready = int'($urandom_range(99)) >= stall;
            @(negedge clk);
            loaded = hi == IMG;
            fin = n_fin != fin0;
            if (in_ready) begin
                chk("ld_we", 32'(bram_we), 32'(in_valid));
                chk("ld_en", 32'(bram_en), 32'(in_valid));
            end
            if (in_valid && in_ready) begin
                chk("wr_addr", 32'(bram_address), 32'(hi));
                chk("wr_data", 32'(bram_in_data), 32'(pix[hi]));
                hi++;
            end
            if (loaded && !fin) chk("quiet_en", 32'(bram_en), 0);
            if (bram_en && !bram_we) begin
                chk("rd_phase", 32'(loaded && fin), 1);
                chk("rd_addr", 32'(bram_address), 32'(OB + oi));
            end
            if (out_valid) begin
                chk("rd_data", 32'(out_data), 32'(pix[oi] ^ key));
                chk("out_last", 32'(out_last), 32'(oi == IMG - 1));
                if (out_ready) begin
                    chk("done", 32'(done), 32'(oi == IMG - 1));
                    if (done) dn++;
                    oi++;
                end else chk("done_stall", 32'(done), 0);
            end else begin
                chk("done_idle", 32'(done), 0);
                chk("last_idle", 32'(out_last), 0);
            end
            if (hold_low) chk("arm_hold", 32'(dskw_start), 0);
            if (dskw_start && !p_start) chk("kick_rise", 32'(p_rdy), 1);
            if (p_start) chk("kick_hold", 32'(dskw_start), 32'(p_rdy));
            p_start = dskw_start;
            p_rdy = dskw_ready;
        end
        chk("job_done", 32'(dn), 1);
        chk("n_written", 32'(hi), IMG);
        chk("n_read", 32'(oi), IMG);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("busy_after", 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_job(0, 0, 1'b1, 1'b0, -1);
        run_job(30, 40, 1'b0, 1'b0, -1);
        run_job(10, 20, 1'b0, 1'b1, -1);
        run_job(0, 0, 1'b0, 1'b0, 400);
        run_job(0, 10, 1'b0, 1'b0, -1);
        run_job(20, 30, 1'b0, 1'b0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
